// File: rtl/conv_top.sv
// Streaming 3x3 convolution engine.
// Raster-order pixels feed two line buffers and a 3x3 window; nine signed
// runtime-writable coefficients weight the window, and the sum is shifted
// and clamped back to the pixel range. Only unpadded (fully covered) window
// positions produce an output. Latency from the accepting edge to valid_out
// is three clocks: line-buffer read, window/product, sum/clamp.
module conv_top #(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 32,
    parameter int IMG_W  = 640,
    parameter int SHIFT  = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     valid_in,
    input  logic [PIX_W-1:0]         px_in,
    input  logic                     kernel_wr,
    input  logic [3:0]               kernel_addr,
    input  logic signed [COEF_W-1:0] kernel_data,
    output logic                     valid_out,
    output logic [PIX_W-1:0]         px_out
);

    localparam int CW = $clog2(IMG_W);
    localparam logic [CW-1:0]           COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0]           COL_TWO  = CW'(2);
    localparam logic signed [ACC_W-1:0] PIX_MAX  = ACC_W'((1 << PIX_W) - 1);
    localparam logic signed [ACC_W-1:0] ACC_ZERO = '0;

    // Position tracking
    logic [CW-1:0] col_q, col_d;
    logic [1:0]    row_q, row_d;
    logic          emit_s;

    // Coefficients, row-major, index 3*r + c
    logic signed [COEF_W-1:0] coef_q [9];

    // Line buffers: lb0 holds row y-1, lb1 holds row y-2
    logic [PIX_W-1:0] lb0_q [IMG_W];
    logic [PIX_W-1:0] lb1_q [IMG_W];

    // Stage 0: registered line-buffer reads plus the incoming pixel
    logic             s0_vld_q;
    logic             s0_out_q;
    logic [PIX_W-1:0] s0_px_q;
    logic [PIX_W-1:0] s0_up1_q;
    logic [PIX_W-1:0] s0_up2_q;

    // Stage 1: 3x3 window, index 3*r + c (r=0 oldest row, c=0 oldest column)
    logic [PIX_W-1:0] win_q [9];
    logic             s1_vld_q;

    // Stage 2: products
    logic signed [ACC_W-1:0] prod_d [9];
    logic signed [ACC_W-1:0] prod_q [9];
    logic                    s2_vld_q;

    // Stage 3: sum, shift, clamp
    logic signed [ACC_W-1:0] sum_s;
    logic signed [ACC_W-1:0] shift_s;
    logic [PIX_W-1:0]        px_d;
    logic                    valid_out_q;
    logic [PIX_W-1:0]        px_out_q;

    // Next column/row; row saturates at 2 since only "at least two rows above" matters
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        emit_s = valid_in && (col_q >= COL_TWO) && (row_q == 2'd2);
        if (valid_in) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == 2'd2) begin
                    row_d = 2'd2;
                end else begin
                    row_d = row_q + 2'd1;
                end
            end else begin
                col_d = col_q + CW'(1);
                row_d = row_q;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // Column/row counters
    always_ff @(posedge clk) begin
        if (!rstn) begin
            col_q <= '0;
            row_q <= 2'd0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Coefficient bank; addresses above 8 are ignored
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 9; i++) begin
                coef_q[i] <= '0;
            end
        end else if (kernel_wr) begin
            for (int i = 0; i < 9; i++) begin
                if (kernel_addr == 4'(i)) begin
                    coef_q[i] <= kernel_data;
                end
            end
        end
    end

    // Line buffers and stage-0 data: read-before-write on each accepted pixel
    always_ff @(posedge clk) begin
        if (valid_in) begin
            lb0_q[col_q] <= px_in;
            lb1_q[col_q] <= lb0_q[col_q];
            s0_up1_q     <= lb0_q[col_q];
            s0_up2_q     <= lb1_q[col_q];
            s0_px_q      <= px_in;
        end
    end

    // Stage-0 tags: window shift request and output-producing marker
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s0_vld_q <= 1'b0;
            s0_out_q <= 1'b0;
        end else begin
            s0_vld_q <= valid_in;
            s0_out_q <= emit_s;
        end
    end

    // Window shift: only on accepted pixels, so idle cycles freeze the window
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
            s1_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= s0_out_q;
            if (s0_vld_q) begin
                win_q[0] <= win_q[1];
                win_q[1] <= win_q[2];
                win_q[2] <= s0_up2_q;
                win_q[3] <= win_q[4];
                win_q[4] <= win_q[5];
                win_q[5] <= s0_up1_q;
                win_q[6] <= win_q[7];
                win_q[7] <= win_q[8];
                win_q[8] <= s0_px_q;
            end
        end
    end

    // Signed coefficient times zero-extended pixel
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            prod_d[i] = ACC_W'(coef_q[i]) * $signed(ACC_W'(win_q[i]));
        end
    end

    // Product registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 9; i++) begin
                prod_q[i] <= '0;
            end
            s2_vld_q <= 1'b0;
        end else begin
            for (int i = 0; i < 9; i++) begin
                prod_q[i] <= prod_d[i];
            end
            s2_vld_q <= s1_vld_q;
        end
    end

    // Sum, arithmetic shift and clamp to the unsigned pixel range
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < 9; i++) begin
            sum_s = sum_s + prod_q[i];
        end
        shift_s = sum_s >>> SHIFT;
        px_d    = '0;
        if (shift_s < ACC_ZERO) begin
            px_d = '0;
        end else if (shift_s > PIX_MAX) begin
            px_d = PIX_MAX[PIX_W-1:0];
        end else begin
            px_d = shift_s[PIX_W-1:0];
        end
    end

    // Output register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_out_q <= 1'b0;
            px_out_q    <= '0;
        end else begin
            valid_out_q <= s2_vld_q;
            px_out_q    <= px_d;
        end
    end

    assign valid_out = valid_out_q;
    assign px_out    = px_out_q;

endmodule

// File: tb/tb_conv_top.sv
// Scoreboard bench for conv_top with an 8-pixel line.
// Expected outputs come from a direct image/kernel model and are queued
// when the triggering pixel is driven, together with the cycle they are due.
module tb_conv_top;

    localparam int W     = 8;
    localparam int SHIFT = 8;

    logic              clk = 1'b0;
    logic              rstn;
    logic              valid_in;
    logic [7:0]        px_in;
    logic              kernel_wr;
    logic [3:0]        kernel_addr;
    logic signed [15:0] kernel_data;
    logic              valid_out;
    logic [7:0]        px_out;

    conv_top #(
        .PIX_W (8),
        .COEF_W(16),
        .ACC_W (32),
        .IMG_W (W),
        .SHIFT (SHIFT)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .valid_in   (valid_in),
        .px_in      (px_in),
        .kernel_wr  (kernel_wr),
        .kernel_addr(kernel_addr),
        .kernel_data(kernel_data),
        .valid_out  (valid_out),
        .px_out     (px_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int val;
        int due;
    } exp_t;

    exp_t   sb[$];
    int     errors = 0;
    int     checks = 0;
    int     n_out  = 0;
    longint coef_m[9];
    int     img[16][W];
    int     mx, my;
    exp_t   mon_e;

    task automatic check_eq(input string tag, input logic signed [63:0] act,
                            input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int model_px(input int x, input int y);
        longint s;
        s = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                s = s + coef_m[3*r+c] * longint'(img[y-2+r][x-2+c]);
            end
        end
        s = s >>> SHIFT;
        if (s < 0) return 0;
        if (s > 255) return 255;
        return int'(s);
    endfunction

    // Output monitor: every valid_out must match the head of the scoreboard
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            n_out++;
            if (sb.size() == 0) begin
                check_eq("spurious_valid", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("px_out", px_out, mon_e.val);
                check_eq("latency", cyc, mon_e.due);
            end
        end
    end

    task automatic step(input logic v, input int p);
        exp_t e;
        @(posedge clk); #1;
        kernel_wr = 1'b0;
        valid_in  = v;
        px_in     = p[7:0];
        if (v) begin
            img[my][mx] = p;
            if (mx >= 2 && my >= 2) begin
                e.val = model_px(mx, my);
                e.due = cyc + 4;
                sb.push_back(e);
            end
            mx++;
            if (mx == W) begin
                mx = 0;
                if (my < 15) my++;
            end
        end
    endtask

    task automatic kwrite(input int a, input int d);
        @(posedge clk); #1;
        valid_in    = 1'b0;
        kernel_wr   = 1'b1;
        kernel_addr = a[3:0];
        kernel_data = d[15:0];
        if (a <= 8) coef_m[a] = d;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        kernel_wr = 1'b0;
        rstn      = 1'b0;
        valid_in  = 1'($urandom_range(0, 1));
        px_in     = 8'($urandom_range(0, 255));
        while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
        mx = 0;
        my = 0;
        for (int i = 0; i < 9; i++) coef_m[i] = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check_eq("rst_valid_out", valid_out, 0);
            check_eq("rst_px_out", px_out, 0);
            valid_in = 1'($urandom_range(0, 1));
            px_in    = 8'($urandom_range(0, 255));
        end
        rstn     = 1'b1;
        valid_in = 1'b0;
        n_out    = 0;
    endtask

    // mode 0: constant cval, 1: ramp 8*y+x, other: random
    task automatic run_frame(input int h, input int mode, input int cval, input int gap);
        int p;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < W; x++) begin
                case (mode)
                    0:       p = cval;
                    1:       p = 8 * y + x;
                    default: p = $urandom_range(0, 255);
                endcase
                while ($urandom_range(0, 99) < gap) step(1'b0, $urandom_range(0, 255));
                step(1'b1, p);
            end
        end
    endtask

    task automatic drain(input int exp_n);
        for (int i = 0; i < 8; i++) step(1'b0, $urandom_range(0, 255));
        check_eq("drain_empty", sb.size(), 0);
        check_eq("out_count", n_out, exp_n);
        n_out = 0;
    endtask

    initial begin
        rstn        = 1'b0;
        valid_in    = 1'b0;
        px_in       = 8'd0;
        kernel_wr   = 1'b0;
        kernel_addr = 4'd0;
        kernel_data = 16'sd0;
        mx          = 0;
        my          = 0;
        for (int i = 0; i < 9; i++) coef_m[i] = 0;

        // Reset with random inputs, then all-zero kernel
        do_reset(10);
        run_frame(4, 2, 0, 0);
        drain(12);

        // Box sum of constant 100
        do_reset(2);
        for (int i = 0; i < 9; i++) kwrite(i, 1);
        run_frame(6, 0, 100, 0);
        drain(24);

        // Identity kernel on a ramp
        do_reset(2);
        kwrite(4, 256);
        run_frame(6, 1, 0, 0);
        drain(24);

        // Clamp high
        do_reset(2);
        for (int i = 0; i < 9; i++) kwrite(i, 256);
        run_frame(4, 0, 200, 0);
        drain(12);

        // Clamp low
        do_reset(2);
        for (int i = 0; i < 9; i++) kwrite(i, -1);
        run_frame(4, 2, 0, 0);
        drain(12);

        // 2*p(x,y) - p(x-2,y-2) on a ramp, then on random pixels
        do_reset(2);
        kwrite(0, -256);
        kwrite(8, 512);
        run_frame(6, 1, 0, 0);
        drain(24);
        do_reset(2);
        kwrite(0, -256);
        kwrite(8, 512);
        run_frame(4, 2, 0, 0);
        drain(12);

        // Box sum with ~50% idle cycles
        do_reset(2);
        for (int i = 0; i < 9; i++) kwrite(i, 1);
        run_frame(6, 0, 100, 50);
        drain(24);

        // Ignored address, then mid-row reset
        do_reset(2);
        kwrite(4, 256);
        kwrite(12, 99);
        run_frame(4, 1, 0, 0);
        drain(12);
        do_reset(2);
        kwrite(4, 256);
        for (int i = 0; i < 2 * W + 5; i++) step(1'b1, i);
        do_reset(3);
        run_frame(4, 2, 0, 0);
        drain(12);
        do_reset(2);
        kwrite(4, 256);
        run_frame(3, 2, 0, 0);
        drain(6);

        // Random kernel, random image, random gaps
        do_reset(2);
        for (int i = 0; i < 9; i++) kwrite(i, $urandom_range(0, 600) - 300);
        run_frame(5, 2, 0, 30);
        drain(18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
